// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths and the AGU pass state machine encoding.
package npu_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } agu_state_t;

endpackage

// File: rtl/iagu_skid_fifo.sv
// Return-data skid FIFO: show-ahead head word, occupancy count, synchronous flush.
// Pushes are only attempted when the producer holds a credit, so the full guard is a safety net.
module iagu_skid_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);

    // Storage write; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/iagu_read_gen.sv
// Input address generator: walks col -> piece -> row over the input feature map, issues IO buffer
// reads under a credit limit, and streams the returned words to the XPE with valid/ready.
module iagu_read_gen
    import npu_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_calculate,
    input  logic [1:0]        buffer_flag,
    input  logic [LEN_W-1:0]  in_x_length,
    input  logic [LEN_W-1:0]  in_y_length,
    input  logic [LEN_W-1:0]  in_piece,
    input  logic [ADDR_W-1:0] addr_start_r,
    input  logic [LEN_W-1:0]  jump_length,
    output logic [ADDR_W-1:0] i_r_addr,
    output logic              i_r_en,
    output logic              i_buffer_select,
    input  logic [DATA_W-1:0] i_r_data,
    output logic [DATA_W-1:0] xpe_in_data,
    output logic              xpe_in_valid,
    input  logic              xpe_in_ready,
    output logic              busy,
    output logic              load_end
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = 8;

    agu_state_t        state_reg;
    agu_state_t        state_next;

    logic [LEN_W-1:0]  x_len_reg;
    logic [LEN_W-1:0]  y_len_reg;
    logic [LEN_W-1:0]  p_len_reg;
    logic [LEN_W-1:0]  jump_reg;
    logic              sel_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  col_reg;
    logic [LEN_W-1:0]  piece_reg;
    logic [LEN_W-1:0]  row_reg;
    logic [RD_LAT-1:0] vpipe_reg;

    logic              zero_len;
    logic              last_col;
    logic              last_piece;
    logic              last_row;
    logic              last_read;
    logic              issue;
    logic              pop;
    logic              credit_ok;
    logic [CW-1:0]     inflight;
    logic [FCW-1:0]    fifo_count;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign zero_len   = (x_len_reg == '0) || (y_len_reg == '0) || (p_len_reg == '0);
    assign last_col   = (col_reg == x_len_reg - LEN_W'(1));
    assign last_piece = (piece_reg == p_len_reg - LEN_W'(1));
    assign last_row   = (row_reg == y_len_reg - LEN_W'(1));
    assign last_read  = last_col && last_piece && last_row;

    // Reads in flight = tagged slots in the latency pipe (the oldest one lands in the FIFO this cycle).
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(vpipe_reg[i]);
        end
    end

    // A start in the same cycle as a handshake cancels the pop; the FIFO is flushed anyway.
    assign pop = xpe_in_valid && xpe_in_ready && !start_calculate;

    // Counting this cycle's pop as a freed slot keeps full rate when FIFO_DEPTH == RD_LAT+1.
    assign credit_ok = (inflight + CW'(fifo_count) - CW'(pop)) < CW'(FIFO_DEPTH);
    assign issue     = (state_reg == ST_ISSUE) && !zero_len && credit_ok && !start_calculate;

    assign i_r_en          = issue;
    assign i_r_addr        = addr_reg;
    assign i_buffer_select = sel_reg;
    assign xpe_in_valid    = !fifo_empty;
    assign xpe_in_data     = xpe_in_valid ? fifo_head : '0;
    assign busy            = (state_reg != ST_IDLE);
    assign load_end        = (state_reg == ST_DONE);

    // Pass state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a start from any state begins a fresh pass.
    always_comb begin
        state_next = state_reg;
        if (start_calculate) begin
            state_next = ST_ISSUE;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_IDLE;
                ST_ISSUE: begin
                    if (zero_len) begin
                        state_next = ST_DONE;
                    end else if (issue && last_read) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && (inflight == '0)) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Config capture at start and address/counter walk per issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_len_reg <= '0;
            y_len_reg <= '0;
            p_len_reg <= '0;
            jump_reg  <= '0;
            sel_reg   <= 1'b0;
            addr_reg  <= '0;
            col_reg   <= '0;
            piece_reg <= '0;
            row_reg   <= '0;
        end else if (start_calculate) begin
            x_len_reg <= in_x_length;
            y_len_reg <= in_y_length;
            p_len_reg <= in_piece;
            jump_reg  <= jump_length;
            sel_reg   <= (buffer_flag != 2'b00);
            addr_reg  <= addr_start_r;
            col_reg   <= '0;
            piece_reg <= '0;
            row_reg   <= '0;
        end else if (issue) begin
            if (last_col && last_piece) begin
                addr_reg  <= addr_reg + ADDR_W'(jump_reg) + ADDR_W'(1);
                col_reg   <= '0;
                piece_reg <= '0;
                row_reg   <= last_row ? '0 : row_reg + LEN_W'(1);
            end else if (last_col) begin
                addr_reg  <= addr_reg + ADDR_W'(1);
                col_reg   <= '0;
                piece_reg <= piece_reg + LEN_W'(1);
            end else begin
                addr_reg  <= addr_reg + ADDR_W'(1);
                col_reg   <= col_reg + LEN_W'(1);
            end
        end
    end

    // Latency pipe tagging which cycles carry valid read data; cleared on start so stale returns drop.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_vpipe
            always_ff @(posedge clk) begin
                if (rst || start_calculate) begin
                    vpipe_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    vpipe_reg[gi] <= issue;
                end else begin
                    vpipe_reg[gi] <= vpipe_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    iagu_skid_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (start_calculate),
        .push      (vpipe_reg[RD_LAT-1]),
        .push_data (i_r_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_iagu_read_gen.sv
// Directed bench for iagu_read_gen with RD_LAT=2, FIFO_DEPTH=4 and a behavioural IO buffer.
module tb_iagu_read_gen;

    logic         clk;
    logic         rst;
    logic         start_calculate;
    logic [1:0]   buffer_flag;
    logic [7:0]   in_x_length;
    logic [7:0]   in_y_length;
    logic [7:0]   in_piece;
    logic [12:0]  addr_start_r;
    logic [7:0]   jump_length;
    logic [12:0]  i_r_addr;
    logic         i_r_en;
    logic         i_buffer_select;
    logic [255:0] i_r_data;
    logic [255:0] xpe_in_data;
    logic         xpe_in_valid;
    logic         xpe_in_ready;
    logic         busy;
    logic         load_end;

    int checks = 0;
    int failures = 0;

    iagu_read_gen #(
        .RD_LAT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_calculate (start_calculate),
        .buffer_flag     (buffer_flag),
        .in_x_length     (in_x_length),
        .in_y_length     (in_y_length),
        .in_piece        (in_piece),
        .addr_start_r    (addr_start_r),
        .jump_length     (jump_length),
        .i_r_addr        (i_r_addr),
        .i_r_en          (i_r_en),
        .i_buffer_select (i_buffer_select),
        .i_r_data        (i_r_data),
        .xpe_in_data     (xpe_in_data),
        .xpe_in_valid    (xpe_in_valid),
        .xpe_in_ready    (xpe_in_ready),
        .busy            (busy),
        .load_end        (load_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] mem_word(input logic [12:0] a);
        return {16{3'b101, a}};
    endfunction

    // Behavioural IO buffer with two cycles of read latency.
    logic         req_en;
    logic [12:0]  req_addr;
    logic [255:0] rd_pipe1;
    always @(negedge clk) begin
        req_en   = i_r_en;
        req_addr = i_r_addr;
    end
    always @(posedge clk) begin
        rd_pipe1 <= req_en ? mem_word(req_addr) : 256'h0;
        i_r_data <= rd_pipe1;
    end

    // Per-pass observations.
    logic [12:0]  q_addr[$];
    int           q_cyc[$];
    logic [255:0] q_data[$];
    logic [12:0]  exp_addr[$];
    int           le_count, le_cyc, le_ndata, start_cyc, bad_inval, max_out, reads_total;
    logic         saw_valid, first_sel, timed_out;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_pass(input logic [7:0] x, input logic [7:0] p, input logic [7:0] y,
                            input logic [12:0] a, input logic [7:0] j, input logic [1:0] bf,
                            input int rmode, input int rst_after,
                            input logic [7:0] x2, input logic [7:0] p2, input logic [7:0] y2,
                            input logic [12:0] a2);
        int  issued;
        int  popped;
        bit  restarted;
        bit  restart_now;
        q_addr.delete(); q_cyc.delete(); q_data.delete();
        le_count = 0; le_cyc = -1; le_ndata = -1; start_cyc = 0; bad_inval = 0; max_out = 0;
        reads_total = 0; saw_valid = 1'b0; first_sel = 1'bx; timed_out = 1'b1;
        issued = 0; popped = 0; restarted = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            restart_now = 1'b0;
            if (cyc == 0) begin
                start_calculate = 1'b1;
                in_x_length = x; in_piece = p; in_y_length = y;
                addr_start_r = a; jump_length = j; buffer_flag = bf;
            end else begin
                @(posedge clk); #1;
                start_calculate = 1'b0;
                in_x_length = 8'hA5; in_piece = 8'h5A; in_y_length = 8'h33;
                addr_start_r = 13'h0ABC; jump_length = 8'h77; buffer_flag = ~bf;
                if (rst_after > 0 && !restarted && reads_total == rst_after) begin
                    start_calculate = 1'b1;
                    in_x_length = x2; in_piece = p2; in_y_length = y2;
                    addr_start_r = a2; jump_length = 8'd0; buffer_flag = bf;
                    restarted = 1'b1; restart_now = 1'b1; start_cyc = cyc;
                end
            end
            xpe_in_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            @(negedge clk);
            if (i_r_en) begin
                q_addr.push_back(i_r_addr);
                q_cyc.push_back(cyc);
                if (q_addr.size() == 1) first_sel = i_buffer_select;
                issued++;
                reads_total++;
            end
            if (xpe_in_valid && xpe_in_ready && !start_calculate) begin
                q_data.push_back(xpe_in_data);
                popped++;
            end
            if (!xpe_in_valid && xpe_in_data != 256'h0) bad_inval++;
            if (xpe_in_valid && !start_calculate) saw_valid = 1'b1;
            if (issued - popped > max_out) max_out = issued - popped;
            if (load_end) begin
                le_count++;
                le_cyc = cyc;
                le_ndata = q_data.size();
            end
            if (restart_now) begin
                q_addr.delete(); q_cyc.delete(); q_data.delete();
                issued = 0; popped = 0; max_out = 0;
            end
            if (le_count > 0 && cyc >= le_cyc + 3) begin
                timed_out = 1'b0;
                break;
            end
        end
        start_calculate = 1'b0;
        xpe_in_ready = 1'b1;
    endtask

    task automatic verify_pass(input string name);
        check({name, "_timeout"}, 256'(timed_out), 256'(0));
        check({name, "_nreads"}, 256'(q_addr.size()), 256'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < q_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 256'(q_addr[i]), 256'(exp_addr[i]));
        end
        check({name, "_nwords"}, 256'(q_data.size()), 256'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < q_data.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), q_data[i], mem_word(exp_addr[i]));
        end
        check({name, "_load_end_count"}, 256'(le_count), 256'(1));
        check({name, "_words_before_load_end"}, 256'(le_ndata), 256'(exp_addr.size()));
        check({name, "_data_zero_when_invalid"}, 256'(bad_inval), 256'(0));
        check({name, "_credit_ok"}, 256'(max_out <= 4), 256'(1));
        check({name, "_busy_after"}, 256'(busy), 256'(0));
    endtask

    initial begin
        rst = 1'b1; start_calculate = 1'b0; buffer_flag = 2'b00;
        in_x_length = 8'd0; in_y_length = 8'd0; in_piece = 8'd0;
        addr_start_r = 13'd0; jump_length = 8'd0; xpe_in_ready = 1'b1;
        i_r_data = 256'h0; rd_pipe1 = 256'h0; req_en = 1'b0; req_addr = 13'd0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_i_r_en", 256'(i_r_en), 256'(0));
        check("reset_i_r_addr", 256'(i_r_addr), 256'(0));
        check("reset_sel", 256'(i_buffer_select), 256'(0));
        check("reset_valid", 256'(xpe_in_valid), 256'(0));
        check("reset_data", xpe_in_data, 256'h0);
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_load_end", 256'(load_end), 256'(0));

        // Test 1: four consecutive reads, buffer 1 selected.
        exp_addr = '{13'h010, 13'h011, 13'h012, 13'h013};
        run_pass(8'd4, 8'd1, 8'd1, 13'h010, 8'd0, 2'b10, 0, 0, 8'd0, 8'd0, 8'd0, 13'd0);
        $display("pass t1_linear reads=%0d words=%0d load_end=%0d", q_addr.size(), q_data.size(), le_count);
        verify_pass("t1");
        check("t1_buffer_select", 256'(first_sel), 256'(1));
        for (int i = 1; i < q_cyc.size(); i++) begin
            check($sformatf("t1_consecutive%0d", i), 256'(q_cyc[i] - q_cyc[0]), 256'(i));
        end

        // Test 2: pieces and rows with jump, buffer 0.
        exp_addr = '{13'd0, 13'd1, 13'd2, 13'd3, 13'd7, 13'd8, 13'd9, 13'd10};
        run_pass(8'd2, 8'd2, 8'd2, 13'h000, 8'd3, 2'b00, 0, 0, 8'd0, 8'd0, 8'd0, 13'd0);
        $display("pass t2_jump reads=%0d words=%0d load_end=%0d", q_addr.size(), q_data.size(), le_count);
        verify_pass("t2");
        check("t2_buffer_select", 256'(first_sel), 256'(0));

        // Test 3: backpressure pattern 1-0-0-1.
        exp_addr = '{13'h020, 13'h021, 13'h022, 13'h023, 13'h024, 13'h025, 13'h026, 13'h027};
        run_pass(8'd8, 8'd1, 8'd1, 13'h020, 8'd0, 2'b01, 1, 0, 8'd0, 8'd0, 8'd0, 13'd0);
        $display("pass t3_backpressure reads=%0d words=%0d max_outstanding=%0d", q_addr.size(), q_data.size(), max_out);
        verify_pass("t3");

        // Test 4: address wrap modulo 8192.
        exp_addr = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        run_pass(8'd4, 8'd1, 8'd1, 13'h1FFE, 8'd0, 2'b00, 0, 0, 8'd0, 8'd0, 8'd0, 13'd0);
        $display("pass t4_wrap reads=%0d words=%0d load_end=%0d", q_addr.size(), q_data.size(), le_count);
        verify_pass("t4");

        // Test 5: zero pieces.
        run_pass(8'd4, 8'd0, 8'd2, 13'h050, 8'd0, 2'b00, 0, 0, 8'd0, 8'd0, 8'd0, 13'd0);
        $display("pass t5_zero reads=%0d load_end=%0d at_cycle=%0d", q_addr.size(), le_count, le_cyc);
        check("t5_timeout", 256'(timed_out), 256'(0));
        check("t5_no_reads", 256'(q_addr.size()), 256'(0));
        check("t5_never_valid", 256'(saw_valid), 256'(0));
        check("t5_load_end_count", 256'(le_count), 256'(1));
        check("t5_load_end_latency", 256'((le_cyc - start_cyc) >= 1 && (le_cyc - start_cyc) <= 2), 256'(1));

        // Test 6: restart after three reads with a new config.
        exp_addr = '{13'h040, 13'h041, 13'h042};
        run_pass(8'd4, 8'd2, 8'd1, 13'h100, 8'd0, 2'b00, 0, 3, 8'd3, 8'd1, 8'd1, 13'h040);
        $display("pass t6_restart reads=%0d words=%0d load_end=%0d", q_addr.size(), q_data.size(), le_count);
        verify_pass("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
